varredor_load_aste: RTL and testbench
=====================================

// Module: varredor_load_aste
// PURPOSE
//   Sweep controller directly upstream of the 16x2 asteroid-load RAM; sole driver of its we/addr/data ports.
//   On each start pulse, walks every slot, reads its 2-bit state and writes back the next state.
//   Slot codes: 00 empty, 01 active, 10 pending load, 11 destroyed.
//   Reports the slots it loads and the per-sweep active total to the game FSM.
// PARAMETERS
//   N_SLOTS    16  slots swept (addresses 0..N_SLOTS-1); must be <= 2**ADDR_W
//   ADDR_W     4   RAM address width
//   MAX_LOADS  4   pending->active promotions allowed per sweep (LOAD_LIMIT_EN only)
// PORTS
//   clk           in   1       rising-edge clock, shared with the RAM
//   reset_n       in   1       asynchronous, active-low reset
//   start         in   1       one-cycle request to begin a sweep
//   mem_q         in   2       RAM read data; registered-address read, valid the cycle after mem_addr is presented
//   mem_addr      out  ADDR_W  RAM address
//   mem_we        out  1       RAM write enable
//   mem_data      out  2       RAM write data
//   busy          out  1       high from the cycle after start until done
//   done          out  1       one-cycle pulse at sweep end
//   load_pulse    out  1       one-cycle pulse when a slot is promoted 10->01
//   load_slot     out  ADDR_W  index of the promoted slot, valid with load_pulse
//   active_count  out  5       slots left at 01 after the last sweep; 0..16
//   load_count    out  5       promotions performed in the last sweep
// BEHAVIOUR
//   Reset (async, reset_n=0): FSM=IDLE, slot index=0; every output is 0.
//   Outputs are registered; mem_we/mem_data/mem_addr are decoded from the FSM state plus registers.
//   IDLE: mem_addr=0, mem_we=0. When start=1: clear the running counters and go to ADDR with index=0.
//   ADDR: mem_addr=index, mem_we=0. Next state is EVAL.
//   EVAL: mem_addr=index and mem_q is valid. Action per mem_q value:
//     10: mem_we=1, mem_data=01, load_pulse=1, load_slot=index, running load +1, running active +1
//     11: mem_we=1, mem_data=00; no count change
//     01: no write; running active +1
//     00: no write
//   From EVAL: if index==N_SLOTS-1 go to DONE; otherwise index+1 and go to ADDR.
//   DONE: done=1 for one cycle; active_count/load_count take the running values; go to IDLE.
//   Latency: done is asserted 2*N_SLOTS+1 cycles after the start edge (33 with the default). busy stays high for the whole sweep.
//   start while busy: ignored, not queued.
//   start in the DONE cycle: ignored.
//   active_count and load_count hold their values between sweeps. They update only in DONE.
//   Counters are 5 bits wide, so 16 cannot wrap.
//   The index never exceeds N_SLOTS-1, so there is no address wrap.
//   Each slot is written at most once per sweep. There is no read-after-write hazard, because every write occurs in EVAL after the slot's read.
//   reset_n low mid-sweep: abort immediately and clear all outputs.
//     Slots already written keep their new state; the rest are unchanged.
//     No partial counts are published.
// CONFIGURATION
//   LOAD_LIMIT_EN defined:
//     Once the running load equals MAX_LOADS, further 10 slots are left as 10 with no write and no load_pulse.
//     They are promoted in a later sweep.
//     11 slots are still cleared.
//   LOAD_LIMIT_EN undefined: every 10 slot is promoted, and MAX_LOADS is unused.
// TESTING
//   RAM at power-on (slot0=10, others 00), start pulse -> load_pulse with load_slot=0 in EVAL of slot 0; RAM[0]=01; done at cycle 33; active_count=1, load_count=1.
//   Repeat the sweep -> no load_pulse, no mem_we; active_count=1, load_count=0.
//   Preload slots 3,7=11 and 5=01 -> slots 3 and 7 written 00; active_count=1 (slot 5); load_count=0.
//   All 16 slots=10 -> 16 load_pulses (load_slot 0..15); active_count=16 and load_count=16 with no wrap. With LOAD_LIMIT_EN and MAX_LOADS=4: slots 0..3 promoted, slots 4..15 still 10, load_count=4; a second sweep promotes 4..7.
//   start pulsed at cycle 10 of a running sweep -> ignored; a single done at cycle 33.
//   reset_n low at cycle 12 -> all outputs 0 and FSM IDLE; a new start performs a full 33-cycle sweep.

Source files
------------

// File: rtl/varredor_load_aste.sv
// -----------------------------------------------------------------------------
// varredor_load_aste
//   Sweep controller for the 16x2 asteroid-load RAM. It is the only driver of
//   the RAM write port. Each start pulse walks every slot, reads its 2-bit
//   state and writes back the next state:
//     00 empty (kept), 01 active (kept, counted), 10 pending -> 01 (load),
//     11 destroyed -> 00.
//   The per-sweep active and load totals are published to the game FSM.
//
//   Optional feature macro: LOAD_LIMIT_EN
//     When it is defined, at most MAX_LOADS pending slots are promoted per
//     sweep. Any further 10 slots stay at 10 and are promoted by a later sweep.
//
// Ports
//   clk           rising-edge clock, shared with the RAM
//   reset_n       asynchronous active-low reset
//   start         one-cycle sweep request (ignored while busy)
//   mem_q         RAM read data, valid the cycle after mem_addr
//   mem_addr      RAM address
//   mem_we        RAM write enable
//   mem_data      RAM write data
//   busy          high from the cycle after start until done
//   done          one-cycle pulse at sweep end
//   load_pulse    one-cycle pulse when a slot is promoted 10->01
//   load_slot     index of the promoted slot, valid with load_pulse
//   active_count  slots left at 01 after the last sweep
//   load_count    promotions performed in the last sweep
// -----------------------------------------------------------------------------
module varredor_load_aste #(
   parameter int N_SLOTS   = 16,
   parameter int ADDR_W    = 4,
   parameter int MAX_LOADS = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        mem_q,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [1:0]        mem_data,
   output logic              busy,
   output logic              done,
   output logic              load_pulse,
   output logic [ADDR_W-1:0] load_slot,
   output logic [4:0]        active_count,
   output logic [4:0]        load_count
);

   // The counters are 5 bits wide, so the slot count must fit in 0..31.
   if ((N_SLOTS < 1) || (N_SLOTS > (2 ** ADDR_W)) || (N_SLOTS > 31) ||
       (MAX_LOADS < 1) || (MAX_LOADS > 31)) begin : g_param_check
      $error("varredor_load_aste: illegal parameter combination");
   end

   localparam logic [ADDR_W-1:0] LAST_IDX_C = ADDR_W'(N_SLOTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] index_r;
   logic [4:0]        run_load_r;
   logic [4:0]        run_active_r;
   logic [4:0]        active_count_r;
   logic [4:0]        load_count_r;
   logic              busy_r;
   logic              done_r;

   logic              limit_s;
   logic              promote_s;
   logic              clear_s;
   logic              active_s;

`ifdef LOAD_LIMIT_EN
   assign limit_s = (run_load_r == 5'(MAX_LOADS));
`else
   assign limit_s = 1'b0;
`endif

   // Slot action decode. It is valid only in EVAL, when mem_q holds the slot's data.
   always_comb begin
      promote_s = 1'b0;
      clear_s   = 1'b0;
      active_s  = 1'b0;
      if (state_r == ST_EVAL) begin
         case (mem_q)
            2'b10: begin
               if (limit_s) begin
                  promote_s = 1'b0;
               end else begin
                  promote_s = 1'b1;
               end
            end
            2'b11:   clear_s  = 1'b1;
            2'b01:   active_s = 1'b1;
            2'b00:   active_s = 1'b0;
            default: active_s = 1'b0;
         endcase
      end else begin
         promote_s = 1'b0;
      end
   end

   // The write-back and the load report must fall in the EVAL cycle, because
   // the slot's read data only arrives in that cycle. They are therefore
   // decoded from the registered state and index.
   assign mem_addr     = index_r;
   assign mem_we       = promote_s | clear_s;
   assign mem_data     = promote_s ? 2'b01 : 2'b00;
   assign load_pulse   = promote_s;
   assign load_slot    = promote_s ? index_r : {ADDR_W{1'b0}};
   assign busy         = busy_r;
   assign done         = done_r;
   assign active_count = active_count_r;
   assign load_count   = load_count_r;

   // Sweep FSM with the running counters and the published results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         index_r        <= {ADDR_W{1'b0}};
         run_load_r     <= 5'd0;
         run_active_r   <= 5'd0;
         active_count_r <= 5'd0;
         load_count_r   <= 5'd0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  run_load_r   <= 5'd0;
                  run_active_r <= 5'd0;
                  index_r      <= {ADDR_W{1'b0}};
                  busy_r       <= 1'b1;
                  state_r      <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               state_r <= ST_EVAL;
            end
            ST_EVAL: begin
               run_load_r   <= run_load_r + {4'd0, promote_s};
               run_active_r <= run_active_r + {4'd0, (promote_s | active_s)};
               if (index_r == LAST_IDX_C) begin
                  // Return the address to 0 so that IDLE presents slot 0.
                  index_r <= {ADDR_W{1'b0}};
                  state_r <= ST_DONE;
               end else begin
                  index_r <= index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_r <= ST_ADDR;
               end
            end
            ST_DONE: begin
               // done rises on the edge that leaves DONE, so it is seen
               // 2*N_SLOTS+1 cycles after the start edge. start is not
               // sampled in this state.
               done_r         <= 1'b1;
               busy_r         <= 1'b0;
               active_count_r <= run_active_r;
               load_count_r   <= run_load_r;
               state_r        <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               index_r <= {ADDR_W{1'b0}};
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_varredor_load_aste.sv
// -----------------------------------------------------------------------------
// tb_varredor_load_aste
//   Directed bench for varredor_load_aste. It contains a behavioural 16x2 RAM
//   with a registered address. Before each sweep, a reference model computes
//   the expected load slots, write count, final RAM image and published
//   counts. The load slots go into a scoreboard queue, and the queue is popped
//   when the DUT reports a load.
// -----------------------------------------------------------------------------
module tb_varredor_load_aste;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mem_q;
   logic [3:0] mem_addr;
   logic       mem_we;
   logic [1:0] mem_data;
   logic       busy;
   logic       done;
   logic       load_pulse;
   logic [3:0] load_slot;
   logic [4:0] active_count;
   logic [4:0] load_count;

   varredor_load_aste dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mem_q(mem_q),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data),
      .busy(busy), .done(done), .load_pulse(load_pulse),
      .load_slot(load_slot), .active_count(active_count),
      .load_count(load_count)
   );

   always #5 clk = ~clk;

   // RAM model. The address is registered, and pre_load overwrites the whole array.
   logic [1:0]  ram [16];
   logic [3:0]  addr_r = 4'd0;
   logic        pre_load = 1'b0;
   logic [31:0] pre_img = 32'd0;

   always @(posedge clk) begin
      addr_r <= mem_addr;
      if (pre_load) begin
         for (int i = 0; i < 16; i++) ram[i] <= pre_img[2*i +: 2];
      end else if (mem_we) begin
         ram[mem_addr] <= mem_data;
      end
   end
   assign mem_q = ram[addr_r];

   int          tests = 0;
   int          fails = 0;
   int          exp_q[$];
   int          exp_we;
   int          exp_act;
   int          exp_load;
   logic [31:0] exp_img;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_ram();
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < 16; i++) v[2*i +: 2] = ram[i];
      return v;
   endfunction

   task automatic preload(input logic [31:0] img);
      @(negedge clk);
      pre_img  = img;
      pre_load = 1'b1;
      @(negedge clk);
      pre_load = 1'b0;
   endtask

   // Reference model. A slot counts as processed once its EVAL write edge has
   // occurred. Slot i is evaluated in sweep cycle 2i+2.
   task automatic build_model(input int stop_cyc);
      logic [1:0] mdl [16];
      exp_q.delete();
      exp_we = 0; exp_act = 0; exp_load = 0;
      for (int i = 0; i < 16; i++) mdl[i] = ram[i];
      for (int i = 0; i < 16; i++) begin
         if (stop_cyc == 0 || (2*i + 2) <= stop_cyc) begin
            case (mdl[i])
               2'b10: begin
`ifdef LOAD_LIMIT_EN
                  if (exp_load < 4) begin
`else
                  if (1'b1) begin
`endif
                     mdl[i] = 2'b01;
                     exp_q.push_back(i);
                     exp_we++; exp_load++; exp_act++;
                  end
               end
               2'b11: begin mdl[i] = 2'b00; exp_we++; end
               2'b01: exp_act++;
               default: ;
            endcase
         end
      end
      exp_img = 32'd0;
      for (int i = 0; i < 16; i++) exp_img[2*i +: 2] = mdl[i];
   endtask

   task automatic run_sweep(input string name, input int glitch_cyc, input int reset_cyc);
      int we_seen;
      int done_seen;
      int done_cyc;
      int popped;
      we_seen = 0; done_seen = 0; done_cyc = -1;
      build_model(reset_cyc);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1 start = 1'b0;
         if (reset_cyc > 0 && cyc == reset_cyc) begin
            reset_n = 1'b0;
            #1;
            chk({name, "_rst_busy"}, busy, 0);
            chk({name, "_rst_done"}, done, 0);
            chk({name, "_rst_we"}, mem_we, 0);
            chk({name, "_rst_addr"}, mem_addr, 0);
            chk({name, "_rst_pulse"}, {load_pulse, load_slot, mem_data}, 0);
            chk({name, "_rst_counts"}, {active_count, load_count}, 0);
            break;
         end
         if (cyc == 1) chk({name, "_busy_c1"}, busy, 1);
         if (load_pulse) begin
            chk({name, "_lq_nonempty"}, (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               popped = exp_q.pop_front();
               chk({name, "_load_slot"}, load_slot, popped);
            end
         end
         if (mem_we) we_seen++;
         if (done) begin
            done_seen++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               chk({name, "_busy_at_done"}, busy, 0);
            end
         end
         if (cyc == 40) chk({name, "_busy_end"}, busy, 0);
         if (glitch_cyc > 0 && cyc == glitch_cyc) start = 1'b1;
      end
      start = 1'b0;
      chk({name, "_lq_left"}, exp_q.size(), 0);
      chk({name, "_we_count"}, we_seen, exp_we);
      chk({name, "_ram"}, pack_ram(), exp_img);
      if (reset_cyc == 0) begin
         chk({name, "_done_cyc"}, done_cyc, 33);
         chk({name, "_done_num"}, done_seen, 1);
         chk({name, "_active_count"}, active_count, exp_act);
         chk({name, "_load_count"}, load_count, exp_load);
      end
   endtask

   initial begin
      // Power-on RAM: slot 0 pending, all others empty.
      preload(32'h0000_0002);
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_mem", {mem_we, mem_addr, mem_data}, 0);
      chk("reset_load", {load_pulse, load_slot}, 0);
      chk("reset_counts", {active_count, load_count}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      run_sweep("pwr", 0, 0);
      run_sweep("rep", 0, 0);
      // Slots 3 and 7 destroyed, slot 5 active.
      preload(32'h0000_C4C0);
      run_sweep("mix", 0, 0);
      // All slots pending, with a stray start at cycle 10 of the sweep.
      preload(32'hAAAA_AAAA);
      run_sweep("all10", 10, 0);
      run_sweep("again", 0, 0);
      // All slots destroyed, then an abort at cycle 12.
      preload(32'hFFFF_FFFF);
      run_sweep("rst", 0, 12);
      @(negedge clk);
      reset_n = 1'b1;
      // Full sweep after the abort, with a start presented in the DONE cycle.
      run_sweep("post", 32, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
